dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the MEM-stage data-memory requests issued by the pipelined datapath.
//   - Accepts one load/store request at a time: word, half or byte.
//   - Services it after a programmable wait, returns load data, and drives Stall so the pipeline freezes meanwhile.
//   - Sits between EX_MEM outputs (address, store data, MemRead/MemWrite/byte/half) and MEM_WB inputs.
// PARAMETERS
//   DEPTH    1024  number of 32-bit words in the backing array (power of 2)
//   LATENCY  2     wait cycles between accept and access, legal range 1..15
//   ADDR_W   log2(DEPTH)  localparam, word-index width
// PORTS
//   Clk        in   1   single clock, rising edge
//   Reset      in   1   asynchronous, active-low reset
//   ReqValid   in   1   request present (MemRead|MemWrite from EX_MEM)
//   ReqWrite   in   1   1=store, 0=load
//   ReqByte    in   1   byte access (wins over ReqHalf)
//   ReqHalf    in   1   halfword access
//   ReqAddr    in   32  byte address
//   ReqWData   in   32  store data; low byte/half used for sb/sh
//   ReqReady   out  1   responder can accept (high only in IDLE)
//   Stall      out  1   freeze PC, IF_ID, ID_EX, EX_MEM
//   RespValid  out  1   one-cycle pulse: access complete
//   RespRData  out  32  load data, sign-extended for byte/half; 0 for stores
//   AlignErr   out  1   one-cycle pulse with RespValid on misaligned access
// BEHAVIOUR
//   - Reset (Reset=0, async): state=IDLE, counter=0, RespValid=0, RespRData=0, AlignErr=0.
//     ReqReady=1 (IDLE). Stall follows its equation (0 unless ReqValid). Array contents are not cleared.
//   - Reset mid-operation aborts the pending access. No write occurs if the access edge has not yet happened.
//   - FSM states: IDLE, WAIT, RESP.
//     - IDLE: ReqValid&ReqReady in cycle T latches addr/data/size/write, cnt<=LATENCY-1, goes to WAIT.
//     - WAIT: cnt!=0 -> cnt--. cnt==0 -> perform the access on this edge, register data/error, go to RESP.
//     - RESP: RespValid=1 for exactly one cycle, ReqReady=0, go to IDLE unconditionally.
//   - Latency: RespValid is high in cycle T+LATENCY+1.
//   - Stall = (IDLE & ReqValid) | WAIT. It is high in cycles T..T+LATENCY and low in the RESP cycle, so the pipeline advances with the data.
//   - Back-to-back: next request is accepted at the earliest in cycle T+LATENCY+2.
//   - Word index = addr[ADDR_W+1:2]. Addresses beyond DEPTH wrap modulo DEPTH.
//   - Byte lanes are little-endian. lane = addr[1:0] for byte, addr[1] for half.
//   - Stores write only the addressed lanes; other lanes are preserved.
//   - Loads: word returns as-is; half/byte are selected and sign-extended to 32 bits.
//   - Stores return RespRData=0.
//   - Request inputs are sampled only at accept. Changes during WAIT are ignored.
//   - ReqValid deasserted while IDLE: nothing happens, Stall=0.
// CONFIGURATION
//   DMEM_ALIGN_CHECK_EN defined:
//     - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//     - Misaligned access: no array write, RespRData=0, AlignErr=1 with RespValid. Timing is unchanged.
//   Not defined:
//     - AlignErr is tied 0.
//     - Low address bits below the access size are ignored, i.e. the address is forced aligned.
// STRUCTURE
//   - dmem_pkg: FSM state encodings (IDLE/WAIT/RESP), size codes (SZ_WORD/SZ_HALF/SZ_BYTE), LATENCY bounds.
//   - Sub-module dmem_lane_ctrl (combinational):
//     - inputs: size, addr[1:0], store data, old word;
//     - outputs: merged write word and extracted, sign-extended load data.
// TESTING
//   1. Reset=0 then release.
//      -> ReqReady=1, RespValid=0, RespRData=0; word 0 reads back its preloaded value.
//   2. LATENCY=2: sw addr=0x10 data=0xDEADBEEF accepted at T.
//      -> Stall high T..T+2, RespValid at T+3; later lw 0x10 returns 0xDEADBEEF.
//   3. After test 2: sb addr=0x11 data=0x7F, then lw 0x10.
//      -> returns 0xDEAD7FEF.
//      lb 0x13 -> 0xFFFFFFDE; lh 0x12 -> 0xFFFFDEAD.
//   4. Reset asserted during WAIT of sw 0x20=0x1234.
//      -> outputs cleared immediately; lw 0x20 afterwards returns the old value; no RespValid for the aborted request.
//   5. With DMEM_ALIGN_CHECK_EN: lh 0x21.
//      -> RespValid & AlignErr same cycle, RespRData=0.
//      Without the macro: sw 0x22 writes word 0x20 and AlignErr stays 0.
//   6. lw addr=DEPTH*4+0x10.
//      -> returns the word at 0x10 (wrap).
//      ReqValid held high continuously -> accepts spaced exactly LATENCY+2 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM states, access size codes and latency bounds for dmem_responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // Byte strobe wins when both byte and half are requested.
  function automatic size_e decode_size(input logic byte_i, input logic half_i);
    if (byte_i) return SZ_BYTE;
    if (half_i) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return lo != 2'b00;
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// rtl/dmem_lane_ctrl.sv - little-endian lane merge for stores and lane extract/sign-extend for loads
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Address bits below the access size are ignored here, which forces alignment.
  always_comb begin
    wr_word  = old_word;
    rd_data  = old_word;
    byte_sel = old_word[{lane, 3'b000} +: 8];
    half_sel = old_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        wr_word[{lane, 3'b000} +: 8] = wdata[7:0];
        rd_data = {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        wr_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rd_data = {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        wr_word = wdata;
        rd_data = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with programmable wait and pipeline stall
// Optional misalignment detection enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqHalf,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        ReqReady,
  output logic        Stall,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        AlignErr
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LAT_EFF = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                           (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_EFF - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  size_e             size_q, size_d;
  logic              write_q, write_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_array [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       wr_word;
  logic [31:0]       rd_data;
  logic              accept;
  logic              access;
  logic              misaligned;
  logic              mem_we;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^ReqAddr[31:ADDR_W+2];

  assign accept   = (state_q == ST_IDLE) && ReqValid;
  assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
  assign word_idx = addr_q[ADDR_W+1:2];
  assign old_word = mem_array[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(size_q, addr_q[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  dmem_lane_ctrl u_lane_ctrl (
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .wdata    (wdata_q),
    .old_word (old_word),
    .wr_word  (wr_word),
    .rd_data  (rd_data)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Contents survive reset; an aborted access never reaches this port because state_q is reset.
  assign mem_we = access && write_q && !misaligned;

  always_ff @(posedge Clk) begin
    if (mem_we) mem_array[word_idx] <= wr_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ReqValid) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      addr_d  = ReqAddr[ADDR_W+1:0];
      wdata_d = ReqWData;
      size_d  = decode_size(ReqByte, ReqHalf);
      write_d = ReqWrite;
      cnt_d   = CNT_INIT;
      err_d   = 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        err_d   = misaligned;
        rdata_d = (write_q || misaligned) ? 32'd0 : rd_data;
      end
    end
  end

  always_comb begin
    ReqReady  = (state_q == ST_IDLE);
    Stall     = ((state_q == ST_IDLE) && ReqValid) || (state_q == ST_WAIT);
    RespValid = (state_q == ST_RESP);
    AlignErr  = (state_q == ST_RESP) && err_q;
    RespRData = rdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a behavioural memory model
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqWrite, ReqByte, ReqHalf;
  logic [31:0] ReqAddr, ReqWData;
  logic        ReqReady, Stall, RespValid, AlignErr;
  logic [31:0] RespRData;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_mem [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqWrite  (ReqWrite),
    .ReqByte   (ReqByte),
    .ReqHalf   (ReqHalf),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .ReqReady  (ReqReady),
    .Stall     (Stall),
    .RespValid (RespValid),
    .RespRData (RespRData),
    .AlignErr  (AlignErr)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // sz: 0 word, 1 half, 2 byte
  function automatic void model_access(input bit wr, input int sz, input logic [31:0] a,
                                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int          idx;
    int          off;
    logic [31:0] w;
    logic [31:0] mask;
    logic [7:0]  b;
    logic [15:0] h;
    idx = int'((a / 4) % DEPTH);
    off = int'(a % 4);
    w   = model_mem[idx];
    rd  = 32'd0;
    err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((sz == 1 && off % 2 != 0) || (sz == 0 && off != 0)) begin
      err = 1'b1;
      return;
    end
`endif
    if (sz == 0) off = 0;
    else if (sz == 1) off = off - off % 2;
    if (sz == 0) begin
      if (wr) w = wd;
      else rd = w;
    end else if (sz == 1) begin
      mask = 32'hFFFF << (8 * off);
      if (wr) w = (w & ~mask) | ((wd & 32'hFFFF) << (8 * off));
      else begin
        h  = 16'(w >> (8 * off));
        rd = 32'($signed(h));
      end
    end else begin
      mask = 32'hFF << (8 * off);
      if (wr) w = (w & ~mask) | ((wd & 32'hFF) << (8 * off));
      else begin
        b  = 8'(w >> (8 * off));
        rd = 32'($signed(b));
      end
    end
    model_mem[idx] = w;
  endfunction

  task automatic drive_req(input bit wr, input int sz, input logic [31:0] a, input logic [31:0] wd);
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqByte  = (sz == 2);
    ReqHalf  = (sz == 1) || ((sz == 2) && ($urandom_range(0, 1) == 1));
    ReqAddr  = a;
    ReqWData = wd;
  endtask

  // Called at a negedge with the responder idle; returns at a negedge with it idle again.
  task automatic do_req(input bit wr, input int sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          exp_err;
    model_access(wr, sz, a, wd, exp_rd, exp_err);
    drive_req(wr, sz, a, wd);
    #1;
    check_eq("stall_accept", {31'd0, Stall}, 32'd1);
    check_eq("ready_accept", {31'd0, ReqReady}, 32'd1);
    @(negedge Clk);
    ReqValid = 1'b0;
    ReqWrite = 1'($urandom);
    ReqAddr  = $urandom;
    ReqWData = $urandom;
    for (int k = 1; k <= LATENCY; k++) begin
      if (k > 1) @(negedge Clk);
      check_eq("stall_wait", {31'd0, Stall}, 32'd1);
      check_eq("resp_early", {31'd0, RespValid}, 32'd0);
    end
    @(negedge Clk);
    check_eq("resp_valid", {31'd0, RespValid}, 32'd1);
    check_eq("stall_resp", {31'd0, Stall}, 32'd0);
    check_eq("ready_resp", {31'd0, ReqReady}, 32'd0);
    check_eq("rdata", RespRData, exp_rd);
    check_eq("align_err", {31'd0, AlignErr}, {31'd0, exp_err});
    @(negedge Clk);
    check_eq("resp_pulse", {31'd0, RespValid}, 32'd0);
    check_eq("ready_idle", {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    int accepts[$];
    Reset    = 1'b0;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqByte  = 1'b0;
    ReqHalf  = 1'b0;
    ReqAddr  = '0;
    ReqWData = '0;
    repeat (3) @(negedge Clk);
    check_eq("rst_ready", {31'd0, ReqReady}, 32'd1);
    check_eq("rst_resp", {31'd0, RespValid}, 32'd0);
    check_eq("rst_rdata", RespRData, 32'd0);
    check_eq("rst_alignerr", {31'd0, AlignErr}, 32'd0);
    check_eq("rst_stall", {31'd0, Stall}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 0, 32'(i * 4), $urandom);

    // contents survive a reset
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    do_req(1'b0, 0, 32'h0, 32'h0);

    do_req(1'b1, 0, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 0, 32'h10, 32'h0);
    do_req(1'b1, 2, 32'h11, 32'h7F);
    do_req(1'b0, 0, 32'h10, 32'h0);
    do_req(1'b0, 2, 32'h13, 32'h0);
    do_req(1'b0, 1, 32'h12, 32'h0);

    // abort a store during WAIT
    drive_req(1'b1, 0, 32'h20, 32'h1234);
    @(negedge Clk);
    ReqValid = 1'b0;
    Reset    = 1'b0;
    #1;
    check_eq("abort_ready", {31'd0, ReqReady}, 32'd1);
    check_eq("abort_stall", {31'd0, Stall}, 32'd0);
    check_eq("abort_rdata", RespRData, 32'd0);
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(negedge Clk);
      check_eq("abort_no_resp", {31'd0, RespValid}, 32'd0);
    end
    Reset = 1'b1;
    @(negedge Clk);
    do_req(1'b0, 0, 32'h20, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    do_req(1'b0, 1, 32'h21, 32'h0);
    do_req(1'b1, 0, 32'h22, 32'hCAFEF00D);
`else
    do_req(1'b1, 0, 32'h22, 32'hCAFEF00D);
`endif
    do_req(1'b0, 0, 32'h20, 32'h0);

    do_req(1'b0, 0, 32'(DEPTH * 4 + 'h10), 32'h0);

    for (int i = 0; i < 150; i++)
      do_req(1'($urandom), int'($urandom_range(0, 2)), $urandom_range(0, DEPTH * 8 - 1), $urandom);

    // ReqValid held high: accepts must be spaced LATENCY+2 cycles apart
    drive_req(1'b0, 0, 32'h10, 32'h0);
    for (int c = 0; c <= 3 * (LATENCY + 2); c++) begin
      if (ReqReady) accepts.push_back(c);
      @(negedge Clk);
    end
    ReqValid = 1'b0;
    repeat (LATENCY + 2) @(negedge Clk);
    check_eq("accept_count", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++)
      check_eq("accept_spacing", 32'(accepts[i] - accepts[i-1]), 32'(LATENCY + 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
